// File: rtl/snow64_memory_access_queue_if.sv
// Bundle of every non-clock signal of snow64_memory_access_queue.
//   Requester side : in_req_* (command in), out_req_ready, out_rsp_* (completion out),
//                    out_busy, out_count.
//   Bus guard side : out_mem_* (issued command), in_mem_cmd_accepted, in_mem_valid,
//                    in_mem_data.
// Modports: slave = the queue itself, master = whatever surrounds it.
interface snow64_memory_access_queue_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  in_req_valid;
    logic                  in_req_is_write;
    logic [ADDR_WIDTH-1:0] in_req_addr;
    logic [DATA_WIDTH-1:0] in_req_data;
    logic                  out_req_ready;

    logic                  out_rsp_valid;
    logic                  out_rsp_is_write;
    logic [DATA_WIDTH-1:0] out_rsp_data;
    logic                  out_busy;
    logic [CW-1:0]         out_count;

    logic                  out_mem_req;
    logic                  out_mem_is_write;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic [DATA_WIDTH-1:0] out_mem_data;
    logic                  in_mem_cmd_accepted;
    logic                  in_mem_valid;
    logic [DATA_WIDTH-1:0] in_mem_data;

    modport slave (
        input  in_req_valid, in_req_is_write, in_req_addr, in_req_data,
        input  in_mem_cmd_accepted, in_mem_valid, in_mem_data,
        output out_req_ready, out_rsp_valid, out_rsp_is_write, out_rsp_data,
        output out_busy, out_count,
        output out_mem_req, out_mem_is_write, out_mem_addr, out_mem_data
    );

    modport master (
        output in_req_valid, in_req_is_write, in_req_addr, in_req_data,
        output in_mem_cmd_accepted, in_mem_valid, in_mem_data,
        input  out_req_ready, out_rsp_valid, out_rsp_is_write, out_rsp_data,
        input  out_busy, out_count,
        input  out_mem_req, out_mem_is_write, out_mem_addr, out_mem_data
    );
endinterface

// File: rtl/snow64_memory_access_queue.sv
// Mixed read/write memory access queue. Buffers up to DEPTH commands in a circular
// queue and issues them one at a time, in order, to the memory bus guard; produces one
// completion pulse per command.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : snow64_memory_access_queue_if.slave (requester and bus guard signals)
// The DEPTH/width parameters must match those of the connected interface.
module snow64_memory_access_queue #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    snow64_memory_access_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    // Queue storage; contents are qualified by count, so no reset is needed.
    logic                  fifo_is_write [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr     [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data     [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;

    logic ready, push, pop, complete;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_is_write_q, mem_is_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_is_write_q, rsp_is_write_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Readiness comes from registered count only; a pop in the same cycle does not
    // make room for a push into a full queue.
    assign ready = (count_q != CW'(DEPTH));
    assign push  = bus.in_req_valid && ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_is_write[wr_ptr_q] <= bus.in_req_is_write;
            fifo_addr[wr_ptr_q]     <= bus.in_req_addr;
            fifo_data[wr_ptr_q]     <= bus.in_req_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Engine: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Engine: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StIssue;
            end
            StIssue: begin
                if (bus.in_mem_cmd_accepted) begin
                    state_d = bus.in_mem_valid ? StIdle : StWait;
                end
            end
            StWait: begin
                if (bus.in_mem_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Engine: pop/complete decode and next values of the registered outputs.
    always_comb begin
        pop            = 1'b0;
        complete       = 1'b0;
        mem_req_d      = mem_req_q;
        mem_is_write_d = mem_is_write_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        unique case (state_q)
            StIdle: begin
                pop       = (count_q != '0);
                mem_req_d = pop;
                if (pop) begin
                    mem_is_write_d = fifo_is_write[rd_ptr_q];
                    mem_addr_d     = fifo_addr[rd_ptr_q];
                    mem_data_d     = fifo_data[rd_ptr_q];
                end
            end
            StIssue: begin
                // Valid before the accept is not a completion.
                if (bus.in_mem_cmd_accepted) begin
                    mem_req_d = 1'b0;
                    complete  = bus.in_mem_valid;
                end
            end
            StWait: begin
                complete = bus.in_mem_valid;
            end
            default: ;
        endcase

        rsp_valid_d    = complete;
        rsp_is_write_d = complete ? mem_is_write_q : rsp_is_write_q;
        // Write completions leave the last read data in place.
        rsp_data_d     = (complete && !mem_is_write_q) ? bus.in_mem_data : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q      <= 1'b0;
            mem_is_write_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            mem_req_q      <= mem_req_d;
            mem_is_write_q <= mem_is_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_write_q <= rsp_is_write_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign bus.out_req_ready    = ready;
    assign bus.out_count        = count_q;
    assign bus.out_busy         = (count_q != '0) || (state_q != StIdle);
    assign bus.out_mem_req      = mem_req_q;
    assign bus.out_mem_is_write = mem_is_write_q;
    assign bus.out_mem_addr     = mem_addr_q;
    assign bus.out_mem_data     = mem_data_q;
    assign bus.out_rsp_valid    = rsp_valid_q;
    assign bus.out_rsp_is_write = rsp_is_write_q;
    assign bus.out_rsp_data     = rsp_data_q;
endmodule

// File: tb/tb_snow64_memory_access_queue.sv
// Self-checking bench for snow64_memory_access_queue: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model (pending-command
// queue plus one in-flight command).
module tb_snow64_memory_access_queue;
    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 256;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snow64_memory_access_queue_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) bus_if ();

    snow64_memory_access_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    cmd_t          pending[$];
    cmd_t          cur;
    cmd_t          mem_m;
    bit            inflight;
    bit            accepted;
    bit            req_m;
    bit            rsp_valid_m;
    bit            rsp_w_m;
    logic [DW-1:0] rsp_data_m;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic model_reset();
        pending.delete();
        inflight    = 1'b0;
        accepted    = 1'b0;
        req_m       = 1'b0;
        rsp_valid_m = 1'b0;
        rsp_w_m     = 1'b0;
        rsp_data_m  = '0;
        mem_m       = '0;
        cur         = '0;
    endtask

    // What one rising edge does, given the inputs held across it.
    task automatic model_edge(input bit push, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit acc, input bit val,
                              input logic [DW-1:0] md);
        bit   room;
        bit   done;
        cmd_t c;
        room        = (pending.size() != DEPTH);
        done        = 1'b0;
        rsp_valid_m = 1'b0;
        if (inflight) begin
            if (!accepted) begin
                if (acc) begin
                    accepted = 1'b1;
                    req_m    = 1'b0;
                    done     = val;
                end
            end else begin
                done = val;
            end
            if (done) begin
                rsp_valid_m = 1'b1;
                rsp_w_m     = cur.is_write;
                if (!cur.is_write) rsp_data_m = md;
                inflight = 1'b0;
            end
        end else if (pending.size() != 0) begin
            cur      = pending.pop_front();
            mem_m    = cur;
            inflight = 1'b1;
            accepted = 1'b0;
            req_m    = 1'b1;
        end
        if (push && room) begin
            c.is_write = w;
            c.addr     = a;
            c.data     = d;
            pending.push_back(c);
        end
    endtask

    task automatic compare_all();
        check("req_ready", bus_if.out_req_ready, pending.size() != DEPTH);
        check("count", bus_if.out_count, pending.size());
        check("count_le_depth", bus_if.out_count <= DEPTH, 1);
        check("busy", bus_if.out_busy, (pending.size() != 0) || inflight);
        check("mem_req", bus_if.out_mem_req, req_m);
        check("mem_is_write", bus_if.out_mem_is_write, mem_m.is_write);
        check("mem_addr", bus_if.out_mem_addr, mem_m.addr);
        check("mem_data", bus_if.out_mem_data, mem_m.data);
        check("rsp_valid", bus_if.out_rsp_valid, rsp_valid_m);
        check("rsp_is_write", bus_if.out_rsp_is_write, rsp_w_m);
        check("rsp_data", bus_if.out_rsp_data, rsp_data_m);
    endtask

    // Called at a falling edge: drive, let one rising edge happen, then compare.
    task automatic step(input bit push, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit acc, input bit val,
                        input logic [DW-1:0] md);
        bus_if.in_req_valid        = push;
        bus_if.in_req_is_write     = w;
        bus_if.in_req_addr         = a;
        bus_if.in_req_data         = d;
        bus_if.in_mem_cmd_accepted = acc;
        bus_if.in_mem_valid        = val;
        bus_if.in_mem_data         = md;
        @(posedge clk);
        model_edge(push, w, a, d, acc, val, md);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, rand256());
    endtask

    task automatic push_cmd(input bit w, input logic [AW-1:0] a, input bit acc, input bit val);
        step(1, w, a, rand256(), acc, val, rand256());
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 1, 1, rand256());
    endtask

    logic [DW-1:0] pat_ab;
    logic [DW-1:0] pat_cd;

    initial begin
        pat_ab = {32{8'hAB}};
        pat_cd = {32{8'hCD}};
        rst_n                      = 1'b0;
        bus_if.in_req_valid        = 1'b0;
        bus_if.in_req_is_write     = 1'b0;
        bus_if.in_req_addr         = '0;
        bus_if.in_req_data         = '0;
        bus_if.in_mem_cmd_accepted = 1'b0;
        bus_if.in_mem_valid        = 1'b0;
        bus_if.in_mem_data         = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1 compare_all();

        // Single read with immediate accept+valid.
        step(1, 0, 64'h100, rand256(), 0, 0, '0);
        idle(1);
        step(0, 0, '0, '0, 1, 1, pat_ab);
        idle(2);

        // Write then read; write waits three cycles after the accept.
        push_cmd(1, 64'h2000, 0, 0);
        push_cmd(0, 64'h2040, 0, 0);
        step(0, 0, '0, '0, 1, 0, rand256());
        idle(2);
        step(0, 0, '0, '0, 0, 1, rand256());
        idle(1);
        step(0, 0, '0, '0, 1, 1, pat_cd);
        idle(2);

        // Fill while the bus guard stalls; the sixth push must be dropped.
        for (int i = 0; i < 6; i++) push_cmd(i[0], 64'h3000 + 64'(i) * 64'h40, 0, 0);
        drain(20);

        // Valid before accept is ignored.
        push_cmd(0, 64'h4000, 0, 0);
        idle(1);
        step(0, 0, '0, '0, 0, 1, rand256());
        step(0, 0, '0, '0, 1, 0, rand256());
        step(0, 0, '0, '0, 0, 1, pat_ab);
        idle(2);

        // Random streaming traffic with random accept/valid delays.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 {$urandom(), $urandom()}, rand256(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2, rand256());
        end
        drain(20);

        // Reset while waiting with two commands queued.
        push_cmd(1, 64'h5000, 0, 0);
        push_cmd(0, 64'h5040, 0, 0);
        push_cmd(0, 64'h5080, 0, 0);
        step(0, 0, '0, '0, 1, 0, rand256());
        check("wait_queued", bus_if.out_count, 2);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1 compare_all();
        @(negedge clk);
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, 1, rand256());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
